// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, issues one-hot stage enables,
// waits on the cache ready handshake and counts retired instructions.
module cycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned COUNT_W     = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               halt_req,
  input  logic               mem_ready,
  input  logic               memReadFlag,
  input  logic               memWriteFlag,
  input  logic               regWriteFlag,
  output logic               fetch_en,
  output logic               decode_en,
  output logic               exec_en,
  output logic               mem_en,
  output logic               wb_en,
  output logic               pc_update_en,
  output logic [2:0]         state,
  output logic               busy,
  output logic               halted,
  output logic               timeout_err,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_ILLEGAL   = 3'd7
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_q;
  logic       rd_q, wr_q, rw_q;
  logic       halt_q;
  logic       retire, timeout, wait_inc, wait_clr, halt_clr;

  // Next-state decode: retire, timeout and wait-counter control.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    retire   = 1'b0;
    timeout  = 1'b0;
    wait_inc = 1'b0;
    halt_clr = 1'b0;
    unique case (state_q)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)                   state_d  = S_DECODE;
        else if (wait_q == TIMEOUT_LIMIT) timeout = 1'b1;
        else                              wait_inc = 1'b1;
      end
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (rd_q || wr_q) state_d = S_MEMORY;
        else if (rw_q)    state_d = S_WRITEBACK;
        else              retire  = 1'b1;
      end
      S_MEMORY: begin
        if (mem_ready) begin
          if (rd_q && rw_q) state_d = S_WRITEBACK;
          else              retire  = 1'b1;
        end else if (wait_q == TIMEOUT_LIMIT) begin
          timeout = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WRITEBACK: retire = 1'b1;
      S_HALT: begin
        if (start) begin
          state_d  = S_FETCH;
          halt_clr = 1'b1;
        end
      end
      default:     state_d = S_IDLE;
    endcase
    // A halt request arriving in the retire cycle itself still stops here.
    if (retire)  state_d = (halt_q || halt_req) ? S_HALT : S_FETCH;
    if (timeout) state_d = S_HALT;
    wait_clr = (state_d != state_q) && (state_d == S_FETCH || state_d == S_MEMORY);
  end

  // State, wait counter, sampled flags, halt latch and retire counter.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rw_q        <= 1'b0;
      halt_q      <= 1'b0;
      timeout_err <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (wait_clr)      wait_q <= '0;
      else if (wait_inc) wait_q <= wait_q + 8'd1;
      if (state_q == S_DECODE) begin
        rd_q <= memReadFlag;
        wr_q <= memWriteFlag;
        rw_q <= regWriteFlag;
      end
      halt_q <= halt_req | (halt_q & ~halt_clr);
      if (timeout) timeout_err <= 1'b1;
      if (retire)  instr_count <= instr_count + COUNT_W'(1);
    end
  end

  assign state        = state_q;
  assign fetch_en     = (state_q == S_FETCH);
  assign decode_en    = (state_q == S_DECODE);
  assign exec_en      = (state_q == S_EXECUTE);
  assign mem_en       = (state_q == S_MEMORY);
  assign wb_en        = (state_q == S_WRITEBACK);
  assign pc_update_en = retire;
  assign busy         = fetch_en | decode_en | exec_en | mem_en | wb_en;
  assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_cycle_sequencer.sv
// Scoreboard bench for cycle_sequencer: the driver pushes each instruction's
// expected retire (stage, count, latency); a monitor pops on pc_update_en.
module tb_cycle_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, halt_req = 1'b0, mem_ready = 1'b0;
  logic        memReadFlag = 1'b0, memWriteFlag = 1'b0, regWriteFlag = 1'b0;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_update_en;
  logic [2:0]  state;
  logic        busy, halted, timeout_err;
  logic [31:0] instr_count;

  cycle_sequencer #(.MEM_TIMEOUT(15), .COUNT_W(32)) dut (
    .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
    .mem_ready(mem_ready), .memReadFlag(memReadFlag), .memWriteFlag(memWriteFlag),
    .regWriteFlag(regWriteFlag), .fetch_en(fetch_en), .decode_en(decode_en),
    .exec_en(exec_en), .mem_en(mem_en), .wb_en(wb_en), .pc_update_en(pc_update_en),
    .state(state), .busy(busy), .halted(halted), .timeout_err(timeout_err),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rd, wr, rw;
    int         fw, mw;     // mem_ready low cycles in FETCH / MEMORY
    int         hmode;      // 0 none, 1 halt_req in DECODE, 2 halt_req in retire cycle
    int         lat;        // hand-computed FETCH-to-retire cycles
    logic [2:0] rstate;     // stage in which the instruction retires
  } instr_t;

  typedef struct {
    logic [2:0]  rstate;
    logic [31:0] count;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency tracking, one-hot enables, and scoreboard pop on retire.
  initial begin
    int         lat = 0;
    logic [2:0] prev = 3'd0;
    exp_t       e;
    forever begin
      @(negedge clock);
      #2;
      if (state == 3'd1 && prev != 3'd1) lat = 1;
      else if (busy)                     lat++;
      prev = state;
      if (busy) check("onehot_enables", $countones({fetch_en, decode_en, exec_en, mem_en, wb_en}), 1);
      if (pc_update_en) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_retire: got pc_update_en=1 expected no retire (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          check("retire_state", 32'(state), 32'(e.rstate));
          check("retire_count", instr_count, e.count);
          check("retire_latency", lat, e.lat);
        end
      end
    end
  end

  // Drives one instruction from FETCH to retire; caller is at a negedge in FETCH.
  task automatic run_instr(input instr_t in);
    int fw_n = 0;
    int mw_n = 0;
    bit done = 0;
    sb_q.push_back('{rstate: in.rstate, count: exp_count, lat: in.lat});
    exp_count++;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      halt_req = 1'b0;
      start    = 1'b0;
      case (state)
        3'd1: begin mem_ready = (fw_n >= in.fw); fw_n++; end
        3'd2: begin
          memReadFlag = in.rd; memWriteFlag = in.wr; regWriteFlag = in.rw;
          halt_req = (in.hmode == 1);
          mem_ready = 1'b1;
        end
        3'd4: begin mem_ready = (mw_n >= in.mw); mw_n++; end
        default: begin
          // Flag, mem_ready and start changes here must be ignored.
          memReadFlag = ~in.rd; memWriteFlag = ~in.wr; regWriteFlag = ~in.rw;
          mem_ready = 1'b1;
          start = (state == 3'd3);
        end
      endcase
      #1;
      if (pc_update_en) begin
        done = 1;
        if (in.hmode == 2) halt_req = 1'b1;
      end
      @(negedge clock);
    end
    halt_req = 1'b0;
    start    = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL instr_budget: got no retire within 64 cycles expected retire (t=%0t)", $time);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_enables"}, 32'({fetch_en, decode_en, exec_en, mem_en, wb_en, pc_update_en}), 0);
    check({tag, "_busy_halted"}, 32'({busy, halted}), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    check({tag, "_count"}, instr_count, 0);
  endtask

  localparam instr_t ALU      = '{rd:0, wr:0, rw:1, fw:0,  mw:0,  hmode:0, lat:4,  rstate:3'd5};
  localparam instr_t LOAD_W2  = '{rd:1, wr:0, rw:1, fw:0,  mw:2,  hmode:0, lat:7,  rstate:3'd5};
  localparam instr_t STORE_F1 = '{rd:0, wr:1, rw:0, fw:1,  mw:0,  hmode:0, lat:5,  rstate:3'd4};
  localparam instr_t BRANCH   = '{rd:0, wr:0, rw:0, fw:0,  mw:0,  hmode:0, lat:3,  rstate:3'd3};
  localparam instr_t ALU_HD   = '{rd:0, wr:0, rw:1, fw:0,  mw:0,  hmode:1, lat:4,  rstate:3'd5};
  localparam instr_t LOAD     = '{rd:1, wr:0, rw:1, fw:0,  mw:0,  hmode:0, lat:5,  rstate:3'd5};
  localparam instr_t BR_HR    = '{rd:0, wr:0, rw:0, fw:0,  mw:0,  hmode:2, lat:3,  rstate:3'd3};
  localparam instr_t ALU_F15  = '{rd:0, wr:0, rw:1, fw:15, mw:0,  hmode:0, lat:19, rstate:3'd5};
  localparam instr_t ST_M15   = '{rd:0, wr:1, rw:0, fw:0,  mw:15, hmode:0, lat:19, rstate:3'd4};

  initial begin
    int n_fetch;
    repeat (3) @(negedge clock);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clock);
    check("idle_hold", 32'(state), 0);

    // ALU reg-write stream: 1,2,3,5 repeating, three retires in 12 busy cycles.
    pulse_start();
    check("start_to_fetch", 32'(state), 1);
    for (int i = 0; i < 3; i++) run_instr(ALU);
    check("count_after_alu", instr_count, 3);

    run_instr(LOAD_W2);
    run_instr(STORE_F1);
    run_instr(BRANCH);
    check("count_after_mix", instr_count, 6);

    // Halt requested in DECODE: instruction completes, then HALT.
    run_instr(ALU_HD);
    check("halt_state", 32'(state), 6);
    check("halt_flag", 32'({halted, busy}), 32'b10);
    check("halt_count", instr_count, 7);
    @(negedge clock);
    check("halt_stays", 32'(state), 6);
    pulse_start();
    check("resume_fetch", 32'(state), 1);
    run_instr(LOAD);
    check("latch_cleared", 32'(state), 1);

    // Halt requested in the retire cycle itself.
    run_instr(BR_HR);
    check("retire_halt_state", 32'(state), 6);
    pulse_start();

    // mem_ready arrives exactly when the wait count equals the limit.
    run_instr(ALU_F15);
    check("boundary_no_err", 32'(timeout_err), 0);

    // FETCH timeout: 15 counted waits, the limit cycle, then HALT.
    mem_ready = 1'b0;
    n_fetch = 0;
    while (state == 3'd1 && n_fetch < 40) begin
      n_fetch++;
      @(negedge clock);
    end
    check("timeout_fetch_cycles", n_fetch, 16);
    check("timeout_state", 32'(state), 6);
    check("timeout_err_set", 32'(timeout_err), 1);
    check("timeout_count", instr_count, 10);
    pulse_start();
    check("timeout_resume", 32'(state), 1);
    check("timeout_err_sticky", 32'(timeout_err), 1);

    run_instr(ST_M15);
    check("count_before_reset", instr_count, 11);

    // Reset mid-MEMORY; start while busy is ignored.
    mem_ready = 1'b1;
    @(negedge clock);
    memReadFlag = 1'b1; memWriteFlag = 1'b0; regWriteFlag = 1'b1;
    mem_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("mid_memory_state", 32'(state), 4);
    start = 1'b1;
    @(negedge clock);
    check("start_ignored", 32'(state), 4);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check_reset_state("midreset");
    reset = 1'b0;
    exp_count = 0;
    @(negedge clock);
    check("post_reset_idle", 32'(state), 0);

    pulse_start();
    run_instr(ALU);
    check("count_after_reset", instr_count, 1);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
